// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the reset sequencer.
// Optional feature macro: RESET_SEQUENCER_WDT_EN (watchdog-triggered sequences).
package reset_sequencer_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    IDLE    = 2'd2
  } seqState_e;

  // Last-reset cause encodings reported on the cause output
  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  // Larger of two integers, used to size the shared interval counter
  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_cnt.sv
// Loadable down-counter with a zero flag, used for both the hold interval
// and the gap between stage releases.
// Loading an interval of length L stores L-1, so the zero flag is seen on
// the L-th edge after the load edge. The count saturates at zero.
module reset_sequencer_cnt #(
  parameter int               WIDTH     = 5,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] loadVal_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: a load wins over a decrement, and a zero count stays put
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = loadVal_i - WIDTH'(1);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Count register, reset to the full hold length
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= RESET_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: holds all downstream resets asserted, then releases them
// one at a time in ascending order. Restarts on a software request or, when
// RESET_SEQUENCER_WDT_EN is defined, on a watchdog expiry.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_OUT     = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sw_rst_req,
  input  logic               wdt_expire,
  output logic [NUM_OUT-1:0] rst_out_n,
  output logic               busy,
  output logic               done,
  output logic [1:0]         cause
);

  localparam int             CW       = $clog2(maxOf(HOLD_CYCLES, STAGE_GAP)) + 1;
  localparam logic [CW-1:0]  HOLD_LEN = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0]  GAP_LEN  = CW'(STAGE_GAP);

  seqState_e          state_q, state_d;
  logic [NUM_OUT-1:0] rstOutN_q, rstOutN_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [1:0]         cause_q, cause_d;

  logic               cntLoad;
  logic [CW-1:0]      cntLoadVal;
  logic               cntDec;
  logic               cntZero;

  logic               wdtReq;
  logic               seqReq;
  logic [NUM_OUT-1:0] releaseNext;
  logic               doRestart;
  logic               doRelease;

`ifdef RESET_SEQUENCER_WDT_EN
  assign wdtReq = wdt_expire;
`else
  logic unusedWdt;
  assign unusedWdt = wdt_expire;
  assign wdtReq    = 1'b0;
`endif

  assign seqReq = sw_rst_req | wdtReq;

  // Releasing the next stage shifts a 1 in from bit 0, so bits only ever
  // release in ascending order
  assign releaseNext = (rstOutN_q << 1) | NUM_OUT'(1);

  reset_sequencer_cnt #(
    .WIDTH     (CW),
    .RESET_VAL (HOLD_LEN)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (cntLoad),
    .loadVal_i (cntLoadVal),
    .dec_i     (cntDec),
    .zero_o    (cntZero)
  );

  // Next-state and output decode; requests are ignored while holding
  always_comb begin
    state_d    = state_q;
    rstOutN_d  = rstOutN_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cause_d    = cause_q;
    cntLoad    = 1'b0;
    cntLoadVal = HOLD_LEN;
    cntDec     = 1'b0;
    doRestart  = 1'b0;
    doRelease  = 1'b0;

    case (state_q)
      HOLD: begin
        if (cntZero) begin
          doRelease = 1'b1;
        end else begin
          cntDec = 1'b1;
        end
      end
      RELEASE: begin
        if (seqReq) begin
          doRestart = 1'b1;
        end else if (cntZero) begin
          doRelease = 1'b1;
        end else begin
          cntDec = 1'b1;
        end
      end
      IDLE: begin
        if (seqReq) begin
          doRestart = 1'b1;
        end
      end
      default: begin
        state_d = HOLD;
      end
    endcase

    if (doRestart) begin
      state_d    = HOLD;
      rstOutN_d  = '0;
      busy_d     = 1'b1;
      cause_d    = wdtReq ? CAUSE_WDT : CAUSE_SW;
      cntLoad    = 1'b1;
      cntLoadVal = HOLD_LEN;
    end else if (doRelease) begin
      rstOutN_d = releaseNext;
      if (&releaseNext) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d    = RELEASE;
        cntLoad    = 1'b1;
        cntLoadVal = GAP_LEN;
      end
    end
  end

  // State and output registers; every output comes straight from a flop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= HOLD;
      rstOutN_q <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      cause_q   <= CAUSE_POR;
    end else begin
      state_q   <= state_d;
      rstOutN_q <= rstOutN_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cause_q   <= cause_d;
    end
  end

  assign rst_out_n = rstOutN_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cause     = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer with default parameters.
// Expected cause for watchdog stimulus follows RESET_SEQUENCER_WDT_EN.
module tb_reset_sequencer;

  localparam int H = 16;
  localparam int G = 4;
  localparam int N = 4;

`ifdef RESET_SEQUENCER_WDT_EN
  localparam bit WDT_EN = 1'b1;
`else
  localparam bit WDT_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         sw_rst_req;
  logic         wdt_expire;
  logic [N-1:0] rst_out_n;
  logic         busy;
  logic         done;
  logic [1:0]   cause;

  int           errors;
  int           checks;
  int           modelK;
  logic [1:0]   modelCause;

  reset_sequencer #(
    .NUM_OUT     (N),
    .HOLD_CYCLES (H),
    .STAGE_GAP   (G)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_rst_req (sw_rst_req),
    .wdt_expire (wdt_expire),
    .rst_out_n  (rst_out_n),
    .busy       (busy),
    .done       (done),
    .cause      (cause)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cause,busy,done,rst_out_n)", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstn, input logic sw, input logic wdt);
    rst_n      = rstn;
    sw_rst_req = sw;
    wdt_expire = wdt;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs k edges after the load edge of the current sequence
  function automatic logic [7:0] expectedVec();
    int           r;
    logic [N-1:0] o;
    logic         b;
    logic         d;
    if (modelK < H) begin
      r = 0;
    end else begin
      r = 1 + (modelK - H) / G;
      if (r > N) r = N;
    end
    o = N'((32'd1 << r) - 1);
    b = (r < N);
    d = (modelK == H + (N - 1) * G);
    return {modelCause, b, d, o};
  endfunction

  task automatic resetFor(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, (i == 1), 1'b0);
      stepEdge();
      checkOutput($sformatf("%s r%0d", tag, i), {cause, busy, done, rst_out_n}, 8'b00_1_0_0000);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    modelK     = -1;
    modelCause = 2'b00;
  endtask

  task automatic runEdges(input int n, input int reqAt, input logic sw, input logic wdt, input string tag);
    for (int i = 0; i < n; i++) begin
      logic reqSampled;
      logic wdtEff;
      if (i == reqAt) applyStimulus(1'b1, sw, wdt);
      wdtEff     = (i == reqAt) && wdt && WDT_EN;
      reqSampled = (i == reqAt) && (sw || wdtEff);
      stepEdge();
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (reqSampled && modelK >= H) begin
        modelK     = 0;
        modelCause = wdtEff ? 2'b10 : 2'b01;
      end else begin
        modelK++;
      end
      checkOutput($sformatf("%s k=%0d", tag, modelK), {cause, busy, done, rst_out_n}, expectedVec());
    end
  endtask

  // Directed scenarios: power-on, requests in each state, combined causes,
  // watchdog only, and a reset that aborts a sequence midway
  initial begin
    errors     = 0;
    checks     = 0;
    modelK     = -1;
    modelCause = 2'b00;
    applyStimulus(1'b0, 1'b0, 1'b0);

    resetFor(3, "por_reset");
    runEdges(34, 5, 1'b1, 1'b0, "por_seq_hold_req");

    runEdges(32, 2, 1'b1, 1'b0, "sw_idle");

    runEdges(1, 0, 1'b1, 1'b0, "sw_start");
    runEdges(40, 22, 1'b1, 1'b0, "sw_release");
    runEdges(12, -1, 1'b0, 1'b0, "settle");

    runEdges(31, 0, 1'b1, 1'b1, "sw_wdt_both");
    runEdges(31, 0, 1'b0, 1'b1, "wdt_only");

    runEdges(19, 0, 1'b1, 1'b0, "pre_abort");
    resetFor(3, "abort_reset");
    runEdges(30, -1, 1'b0, 1'b0, "rerun");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
